// File: rtl/dcache_dual_core_arb_pkg.sv
// Shared constants for the dual-core dcache request arbiter and its round-robin grant block.
package dcache_dual_core_arb_pkg;

  localparam int unsigned DCACHE_ARB_TAG_BITS_DEF = 14;
  localparam int unsigned DCACHE_ARB_CORE_ID_BIT  = DCACHE_ARB_TAG_BITS_DEF;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  function automatic logic [1:0] core_onehot(input logic id);
    return (id == CORE1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dcache_dual_core_arb_rr_arb2.sv
// rr_arb2: two-input round-robin grant; pointer favours the core not granted last.
module rr_arb2
  import dcache_dual_core_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt,
  output logic       o_gnt_id
);

  logic r_ptr;
  logic w_gnt_id;

  always_comb begin
    w_gnt_id = CORE0;
    if (i_req[0] && i_req[1]) begin
      w_gnt_id = r_ptr;
    end else if (i_req[1]) begin
      w_gnt_id = CORE1;
    end
  end

  assign o_gnt    = i_req & core_onehot(w_gnt_id);
  assign o_gnt_id = w_gnt_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= CORE0;
    end else if (i_accept) begin
      r_ptr <= ~w_gnt_id;
    end
  end

endmodule

// File: rtl/dcache_dual_core_arb.sv
// Registered round-robin arbiter: two cores onto one dcache request port, responses steered by tag MSB.
// Optional perf counters when DCACHE_ARB_PERF_EN is defined.
module dcache_dual_core_arb
  import dcache_dual_core_arb_pkg::*;
#(
  parameter int unsigned CORE_TAG_BITS = DCACHE_ARB_CORE_ID_BIT,
  parameter int unsigned ADDR_BITS     = 32,
  parameter int unsigned DATA_BITS     = 128,
  parameter int unsigned OP_BITS       = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     reset_core0,
  input  logic                     reset_core1,
  input  logic                     core0_req_val,
  output logic                     core0_req_rdy,
  input  logic [OP_BITS-1:0]       core0_req_op,
  input  logic [ADDR_BITS-1:0]     core0_req_addr,
  input  logic [DATA_BITS-1:0]     core0_req_data,
  input  logic [DATA_BITS/8-1:0]   core0_req_wmask,
  input  logic [CORE_TAG_BITS-1:0] core0_req_tag,
  input  logic                     core1_req_val,
  output logic                     core1_req_rdy,
  input  logic [OP_BITS-1:0]       core1_req_op,
  input  logic [ADDR_BITS-1:0]     core1_req_addr,
  input  logic [DATA_BITS-1:0]     core1_req_data,
  input  logic [DATA_BITS/8-1:0]   core1_req_wmask,
  input  logic [CORE_TAG_BITS-1:0] core1_req_tag,
  output logic                     dc_req_val,
  input  logic                     dc_req_rdy,
  output logic [OP_BITS-1:0]       dc_req_op,
  output logic [ADDR_BITS-1:0]     dc_req_addr,
  output logic [DATA_BITS-1:0]     dc_req_data,
  output logic [DATA_BITS/8-1:0]   dc_req_wmask,
  output logic [CORE_TAG_BITS:0]   dc_req_tag,
  input  logic                     dc_resp_val,
  input  logic [DATA_BITS-1:0]     dc_resp_data,
  input  logic [CORE_TAG_BITS:0]   dc_resp_tag,
  output logic                     core0_resp_val,
  output logic                     core1_resp_val,
  output logic [DATA_BITS-1:0]     core_resp_data,
  output logic [CORE_TAG_BITS-1:0] core_resp_tag
`ifdef DCACHE_ARB_PERF_EN
  ,
  input  logic                     perf_clear,
  output logic [31:0]              perf_grant0,
  output logic [31:0]              perf_grant1,
  output logic [31:0]              perf_conflict
`endif
);

  logic                     w_eff_val0;
  logic                     w_eff_val1;
  logic                     w_load;
  logic                     w_accept;
  logic [1:0]               w_gnt;
  logic                     w_gnt_id;

  logic                     r_val;
  logic [OP_BITS-1:0]       r_op;
  logic [ADDR_BITS-1:0]     r_addr;
  logic [DATA_BITS-1:0]     r_data;
  logic [DATA_BITS/8-1:0]   r_wmask;
  logic [CORE_TAG_BITS:0]   r_tag;

  assign w_eff_val0 = core0_req_val & ~reset_core0;
  assign w_eff_val1 = core1_req_val & ~reset_core1;

  // Single-entry output stage refills in the same cycle the dcache drains it.
  assign w_load   = ~r_val | dc_req_rdy;
  assign w_accept = |w_gnt & w_load;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_req    ({w_eff_val1, w_eff_val0}),
    .i_accept (w_accept),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  assign core0_req_rdy = w_gnt[0] & w_load;
  assign core1_req_rdy = w_gnt[1] & w_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_val   <= 1'b0;
      r_op    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wmask <= '0;
      r_tag   <= '0;
    end else if (w_load) begin
      r_val <= w_accept;
      if (w_accept) begin
        if (w_gnt_id == CORE1) begin
          r_op    <= core1_req_op;
          r_addr  <= core1_req_addr;
          r_data  <= core1_req_data;
          r_wmask <= core1_req_wmask;
          r_tag   <= {CORE1, core1_req_tag};
        end else begin
          r_op    <= core0_req_op;
          r_addr  <= core0_req_addr;
          r_data  <= core0_req_data;
          r_wmask <= core0_req_wmask;
          r_tag   <= {CORE0, core0_req_tag};
        end
      end
    end
  end

  assign dc_req_val   = r_val;
  assign dc_req_op    = r_op;
  assign dc_req_addr  = r_addr;
  assign dc_req_data  = r_data;
  assign dc_req_wmask = r_wmask;
  assign dc_req_tag   = r_tag;

  assign core0_resp_val = dc_resp_val & (dc_resp_tag[CORE_TAG_BITS] == CORE0) & ~reset_core0;
  assign core1_resp_val = dc_resp_val & (dc_resp_tag[CORE_TAG_BITS] == CORE1) & ~reset_core1;
  assign core_resp_data = dc_resp_data;
  assign core_resp_tag  = dc_resp_tag[CORE_TAG_BITS-1:0];

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] r_perf_grant0;
  logic [31:0] r_perf_grant1;
  logic [31:0] r_perf_conflict;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_grant0   <= '0;
      r_perf_grant1   <= '0;
      r_perf_conflict <= '0;
    end else if (perf_clear) begin
      r_perf_grant0   <= '0;
      r_perf_grant1   <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (core0_req_rdy) r_perf_grant0 <= r_perf_grant0 + 32'd1;
      if (core1_req_rdy) r_perf_grant1 <= r_perf_grant1 + 32'd1;
      if (w_eff_val0 && w_eff_val1) r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_grant0   = r_perf_grant0;
  assign perf_grant1   = r_perf_grant1;
  assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_dcache_dual_core_arb.sv
// Scoreboard bench for dcache_dual_core_arb; perf checks run when DCACHE_ARB_PERF_EN is defined.
module tb_dcache_dual_core_arb;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         reset_core0, reset_core1;
  logic         core0_req_val, core1_req_val;
  logic         core0_req_rdy, core1_req_rdy;
  logic [3:0]   core0_req_op, core1_req_op;
  logic [31:0]  core0_req_addr, core1_req_addr;
  logic [127:0] core0_req_data, core1_req_data;
  logic [15:0]  core0_req_wmask, core1_req_wmask;
  logic [13:0]  core0_req_tag, core1_req_tag;
  logic         dc_req_val, dc_req_rdy;
  logic [3:0]   dc_req_op;
  logic [31:0]  dc_req_addr;
  logic [127:0] dc_req_data;
  logic [15:0]  dc_req_wmask;
  logic [14:0]  dc_req_tag;
  logic         dc_resp_val;
  logic [127:0] dc_resp_data;
  logic [14:0]  dc_resp_tag;
  logic         core0_resp_val, core1_resp_val;
  logic [127:0] core_resp_data;
  logic [13:0]  core_resp_tag;
`ifdef DCACHE_ARB_PERF_EN
  logic         perf_clear;
  logic [31:0]  perf_grant0, perf_grant1, perf_conflict;
`endif

  typedef struct {
    logic [14:0]  tag;
    logic [3:0]   op;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  wmask;
  } exp_t;

  exp_t sb_q[$];
  logic id_log[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc0 = 0;
  int   n_acc1 = 0;

  dcache_dual_core_arb dut (
    .clk(clk), .reset_n(reset_n), .reset_core0(reset_core0), .reset_core1(reset_core1),
    .core0_req_val(core0_req_val), .core0_req_rdy(core0_req_rdy), .core0_req_op(core0_req_op),
    .core0_req_addr(core0_req_addr), .core0_req_data(core0_req_data),
    .core0_req_wmask(core0_req_wmask), .core0_req_tag(core0_req_tag),
    .core1_req_val(core1_req_val), .core1_req_rdy(core1_req_rdy), .core1_req_op(core1_req_op),
    .core1_req_addr(core1_req_addr), .core1_req_data(core1_req_data),
    .core1_req_wmask(core1_req_wmask), .core1_req_tag(core1_req_tag),
    .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_op(dc_req_op),
    .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_wmask(dc_req_wmask),
    .dc_req_tag(dc_req_tag), .dc_resp_val(dc_resp_val), .dc_resp_data(dc_resp_data),
    .dc_resp_tag(dc_resp_tag), .core0_resp_val(core0_resp_val), .core1_resp_val(core1_resp_val),
    .core_resp_data(core_resp_data), .core_resp_tag(core_resp_tag)
`ifdef DCACHE_ARB_PERF_EN
    , .perf_clear(perf_clear), .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
    .perf_conflict(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_core(input int c, input logic val, input logic [13:0] tag);
    if (c == 0) begin
      core0_req_val   = val;
      core0_req_tag   = tag;
      core0_req_op    = tag[3:0];
      core0_req_addr  = 32'h1000_0000 | 32'(tag);
      core0_req_data  = {4{32'hC0C0_0000 | 32'(tag)}};
      core0_req_wmask = 16'hFFFF ^ 16'(tag);
    end else begin
      core1_req_val   = val;
      core1_req_tag   = tag;
      core1_req_op    = ~tag[3:0];
      core1_req_addr  = 32'h2010_0000 | 32'(tag);
      core1_req_data  = {4{32'hC1C1_0000 | 32'(tag)}};
      core1_req_wmask = 16'h5A5A ^ 16'(tag);
    end
  endtask

  // Monitor: pops and checks issued entries before recording new accepts in the same cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
    end else begin
      if (dc_req_val) begin
        check_eq("sb_pending", 128'(sb_q.size() != 0), 128'(1));
        if (sb_q.size() != 0) begin
          check_eq("req_tag",   128'(dc_req_tag),   128'(sb_q[0].tag));
          check_eq("req_op",    128'(dc_req_op),    128'(sb_q[0].op));
          check_eq("req_addr",  128'(dc_req_addr),  128'(sb_q[0].addr));
          check_eq("req_data",  dc_req_data,        sb_q[0].data);
          check_eq("req_wmask", 128'(dc_req_wmask), 128'(sb_q[0].wmask));
          if (dc_req_rdy) begin
            id_log.push_back(dc_req_tag[14]);
            void'(sb_q.pop_front());
          end
        end
      end
      check_eq("rdy_exclusive", 128'(core0_req_rdy & core1_req_rdy), 128'(0));
      if (core0_req_val && core0_req_rdy) begin
        sb_q.push_back('{tag: {1'b0, core0_req_tag}, op: core0_req_op, addr: core0_req_addr,
                         data: core0_req_data, wmask: core0_req_wmask});
        n_acc0++;
      end
      if (core1_req_val && core1_req_rdy) begin
        sb_q.push_back('{tag: {1'b1, core1_req_tag}, op: core1_req_op, addr: core1_req_addr,
                         data: core1_req_data, wmask: core1_req_wmask});
        n_acc1++;
      end
    end
  end

  task automatic run_both_six();
    id_log.delete();
    n_acc0 = 0;
    n_acc1 = 0;
    @(posedge clk); #1;
    dc_req_rdy = 1'b1;
    drive_core(0, 1'b1, 14'h0101);
    drive_core(1, 1'b1, 14'h0202);
    repeat (6) @(posedge clk);
    #1;
    core0_req_val = 1'b0;
    core1_req_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    reset_core0 = 1'b0;
    reset_core1 = 1'b0;
    drive_core(0, 1'b0, 14'h0);
    drive_core(1, 1'b0, 14'h0);
    dc_req_rdy = 1'b0;
    dc_resp_val = 1'b0;
    dc_resp_data = '0;
    dc_resp_tag = '0;
`ifdef DCACHE_ARB_PERF_EN
    perf_clear = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_dc_req_val", 128'(dc_req_val), 128'(0));
`ifdef DCACHE_ARB_PERF_EN
    check_eq("rst_perf_g0", 128'(perf_grant0), 128'(0));
    check_eq("rst_perf_conf", 128'(perf_conflict), 128'(0));
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: contention alternates starting from core0
    run_both_six();
    repeat (3) @(posedge clk);
    #1;
    check_eq("s1_issued", 128'(id_log.size()), 128'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < id_log.size()) check_eq("s1_id_order", 128'(id_log[i]), 128'(i % 2));
    end
    check_eq("s1_acc0", 128'(n_acc0), 128'(3));
    check_eq("s1_acc1", 128'(n_acc1), 128'(3));

    // 2: stalled output held stable, core0 back-pressured
    dc_req_rdy = 1'b0;
    drive_core(0, 1'b1, 14'h0005);
    @(posedge clk); #1;
    drive_core(0, 1'b1, 14'h0006);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("s2_val", 128'(dc_req_val), 128'(1));
      check_eq("s2_tag", 128'(dc_req_tag), 128'(15'h0005));
      check_eq("s2_rdy0", 128'(core0_req_rdy), 128'(0));
    end
    @(posedge clk); #1;
    dc_req_rdy = 1'b1;
    @(negedge clk);
    check_eq("s2_rdy0_release", 128'(core0_req_rdy), 128'(1));
    @(posedge clk); #1;
    core0_req_val = 1'b0;
    @(negedge clk);
    check_eq("s2_second_tag", 128'(dc_req_tag), 128'(15'h0006));
    @(posedge clk); #1;

    // 3: response routing
    dc_resp_val = 1'b1;
    dc_resp_tag = 15'h4003;
    dc_resp_data = {4{32'hDEAD_BEEF}};
    #1;
    check_eq("s3_resp1", 128'(core1_resp_val), 128'(1));
    check_eq("s3_resp0", 128'(core0_resp_val), 128'(0));
    check_eq("s3_rtag", 128'(core_resp_tag), 128'(14'h0003));
    check_eq("s3_rdata", core_resp_data, {4{32'hDEAD_BEEF}});
    dc_resp_tag = 15'h0007;
    #1;
    check_eq("s3_resp0b", 128'(core0_resp_val), 128'(1));
    check_eq("s3_resp1b", 128'(core1_resp_val), 128'(0));
    check_eq("s3_rtagb", 128'(core_resp_tag), 128'(14'h0007));
    dc_resp_val = 1'b0;

    // 4: core1 entry in flight survives reset_core1; later requests/responses dropped
    @(posedge clk); #1;
    dc_req_rdy = 1'b0;
    drive_core(1, 1'b1, 14'h0009);
    @(posedge clk); #1;
    reset_core1 = 1'b1;
    drive_core(1, 1'b1, 14'h000A);
    repeat (2) begin
      @(negedge clk);
      check_eq("s4_stall_val", 128'(dc_req_val), 128'(1));
      check_eq("s4_rdy1", 128'(core1_req_rdy), 128'(0));
    end
    @(posedge clk); #1;
    dc_req_rdy = 1'b1;
    @(negedge clk);
    check_eq("s4_issue_tag", 128'(dc_req_tag), 128'(15'h4009));
    check_eq("s4_rdy1_rst", 128'(core1_req_rdy), 128'(0));
    repeat (2) begin
      @(negedge clk);
      check_eq("s4_no_issue", 128'(dc_req_val), 128'(0));
    end
    dc_resp_val = 1'b1;
    dc_resp_tag = 15'h4001;
    #1;
    check_eq("s4_resp1_drop", 128'(core1_resp_val), 128'(0));
    check_eq("s4_resp0", 128'(core0_resp_val), 128'(0));
    dc_resp_val = 1'b0;
    core1_req_val = 1'b0;
    @(posedge clk); #1;
    reset_core1 = 1'b0;

    // 5: async reset mid-stall, pointer returns to core0
    dc_req_rdy = 1'b0;
    drive_core(0, 1'b1, 14'h0011);
    @(posedge clk); #1;
    core0_req_val = 1'b0;
    @(posedge clk); #3;
    check_eq("s5_pre_val", 128'(dc_req_val), 128'(1));
    reset_n = 1'b0;
    #1;
    check_eq("s5_async_clr", 128'(dc_req_val), 128'(0));
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    dc_req_rdy = 1'b1;
    drive_core(0, 1'b1, 14'h0021);
    drive_core(1, 1'b1, 14'h0022);
    @(negedge clk);
    check_eq("s5_first_rdy0", 128'(core0_req_rdy), 128'(1));
    check_eq("s5_first_rdy1", 128'(core1_req_rdy), 128'(0));
    @(posedge clk); #1;
    core0_req_val = 1'b0;
    core1_req_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef DCACHE_ARB_PERF_EN
    // 6: perf counters over the contention pattern, then clear
    perf_clear = 1'b1;
    @(posedge clk); #1;
    perf_clear = 1'b0;
    run_both_six();
    @(negedge clk);
    check_eq("s6_grant0", 128'(perf_grant0), 128'(3));
    check_eq("s6_grant1", 128'(perf_grant1), 128'(3));
    check_eq("s6_conflict", 128'(perf_conflict), 128'(6));
    @(posedge clk); #1;
    perf_clear = 1'b1;
    @(posedge clk); #1;
    perf_clear = 1'b0;
    check_eq("s6_clr_g0", 128'(perf_grant0), 128'(0));
    check_eq("s6_clr_g1", 128'(perf_grant1), 128'(0));
    check_eq("s6_clr_conf", 128'(perf_conflict), 128'(0));
    repeat (3) @(posedge clk);
    #1;
`endif

    check_eq("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
